// File: rtl/nv_nvdla_cacc_calc_seq_pkg.sv
// Shared types and constants for the CACC calc sequencer: state encoding,
// calc pipeline latency and counter/address widths.
package nv_nvdla_cacc_calc_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    localparam int CALC_LAT       = 3;
    localparam int ADDR_W         = 7;
    localparam int PASS_W         = 8;
    localparam int KGRP_W         = 12;
    localparam int PD_W           = 22;
    localparam int DLV_DEPTH_DFLT = 16;
    localparam int CRD_W          = $clog2(DLV_DEPTH_DFLT + 1);
    localparam int DRAIN_W        = $clog2(CALC_LAT + 1);

endpackage

// File: rtl/nv_nvdla_cacc_seq_credit.sv
// Delivery-buffer credit counter: starts full, a simultaneous take and return
// cancel, and a return while already full is dropped.
module nv_nvdla_cacc_seq_credit
    import nv_nvdla_cacc_calc_seq_pkg::*;
#(
    parameter int DEPTH = DLV_DEPTH_DFLT,
    parameter int W     = CRD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         take,
    input  logic         ret,
    output logic [W-1:0] credit
);

    localparam logic [W-1:0] FULL = W'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= FULL;
        end else if (take && !ret) begin
            credit <= credit - 1'b1;
        end else if (ret && !take && (credit != FULL)) begin
            credit <= credit + 1'b1;
        end
    end

endmodule

// File: rtl/nv_nvdla_cacc_calc_seq.sv
// Int8 accumulation calc sequencer: walks atom/pass/kernel-group counters, feeds the
// calc unit, reads/writes partial sums. Optional sat counter: NVDLA_CACC_SEQ_SAT_CNT_EN.
module nv_nvdla_cacc_calc_seq
    import nv_nvdla_cacc_calc_seq_pkg::*;
#(
    parameter int DLV_DEPTH = DLV_DEPTH_DFLT
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              op_en,
    input  logic [ADDR_W-1:0] cfg_stripe_len,
    input  logic [PASS_W-1:0] cfg_chn_pass,
    input  logic [KGRP_W-1:0] cfg_kernel_grp,
    input  logic              dat_pvld,
    output logic              dat_prdy,
    input  logic [PD_W-1:0]   dat_pd,
    output logic              abuf_rd_en,
    output logic [ADDR_W-1:0] abuf_rd_addr,
    output logic              abuf_wr_en,
    output logic [ADDR_W-1:0] abuf_wr_addr,
    output logic              calc_in_valid,
    output logic              calc_in_sel,
    output logic              calc_in_op_valid,
    output logic [PD_W-1:0]   calc_in_data,
    input  logic              calc_out_final_sat,
    input  logic              dlv_credit_ret,
    output logic              layer_done,
    output logic [31:0]       sat_cnt
);

    localparam int CW = $clog2(DLV_DEPTH + 1);

    seq_state_t          state;
    logic [ADDR_W-1:0]   atom_cnt, cfg_stripe;
    logic [PASS_W-1:0]   pass_cnt, cfg_pass;
    logic [KGRP_W-1:0]   kgrp_cnt, cfg_kgrp;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [CALC_LAT-1:0] vld_p, sel_p;
    logic [ADDR_W-1:0]   addr_p [CALC_LAT];
    logic [CW-1:0]       credit;
    logic                start, final_pass, need_rd, raw_hazard, accept, crd_empty;

    assign start      = (state == SEQ_IDLE) && op_en;
    assign final_pass = (pass_cnt == cfg_pass);
    assign need_rd    = (pass_cnt != '0);
    assign crd_empty  = (credit == '0);

    // A read must not overtake a writeback of the same address still in the calc pipe.
    always_comb begin
        raw_hazard = 1'b0;
        for (int i = 0; i < CALC_LAT; i++) begin
            if (vld_p[i] && !sel_p[i] && (addr_p[i] == atom_cnt)) begin
                raw_hazard = 1'b1;
            end
        end
        raw_hazard = raw_hazard && need_rd;
    end

    assign dat_prdy     = (state == SEQ_RUN) && !raw_hazard && !(final_pass && crd_empty);
    assign accept       = dat_pvld && dat_prdy;
    assign abuf_rd_en   = accept && need_rd;
    assign abuf_rd_addr = abuf_rd_en ? atom_cnt : '0;
    assign abuf_wr_en   = vld_p[CALC_LAT-1] && !sel_p[CALC_LAT-1];
    assign abuf_wr_addr = abuf_wr_en ? addr_p[CALC_LAT-1] : '0;

    nv_nvdla_cacc_seq_credit #(
        .DEPTH (DLV_DEPTH),
        .W     (CW)
    ) u_credit (
        .clk    (nvdla_core_clk),
        .rst_n  (nvdla_core_rstn),
        .take   (accept && final_pass),
        .ret    (dlv_credit_ret),
        .credit (credit)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state      <= SEQ_IDLE;
            atom_cnt   <= '0;
            pass_cnt   <= '0;
            kgrp_cnt   <= '0;
            cfg_stripe <= '0;
            cfg_pass   <= '0;
            cfg_kgrp   <= '0;
            drain_cnt  <= '0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        cfg_stripe <= cfg_stripe_len;
                        cfg_pass   <= cfg_chn_pass;
                        cfg_kgrp   <= cfg_kernel_grp;
                        atom_cnt   <= '0;
                        pass_cnt   <= '0;
                        kgrp_cnt   <= '0;
                        state      <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (accept) begin
                        if (atom_cnt == cfg_stripe) begin
                            atom_cnt <= '0;
                            if (final_pass) begin
                                pass_cnt <= '0;
                                if (kgrp_cnt == cfg_kgrp) begin
                                    kgrp_cnt  <= '0;
                                    drain_cnt <= '0;
                                    state     <= SEQ_DRAIN;
                                end else begin
                                    kgrp_cnt <= kgrp_cnt + 1'b1;
                                end
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end
                        end else begin
                            atom_cnt <= atom_cnt + 1'b1;
                        end
                    end
                end
                SEQ_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(CALC_LAT - 1)) begin
                        state      <= SEQ_DONE;
                        layer_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                SEQ_DONE: state <= SEQ_IDLE;
                default:  state <= SEQ_IDLE;
            endcase
        end
    end

    // Stage p0: calc inputs registered one cycle after accept; writeback tags shift along.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            calc_in_valid    <= 1'b0;
            calc_in_sel      <= 1'b0;
            calc_in_op_valid <= 1'b0;
            calc_in_data     <= '0;
            vld_p            <= '0;
            sel_p            <= '0;
        end else begin
            calc_in_valid <= accept;
            if (accept) begin
                calc_in_data     <= dat_pd;
                calc_in_op_valid <= need_rd;
                calc_in_sel      <= final_pass;
            end
            vld_p <= {vld_p[CALC_LAT-2:0], accept};
            sel_p <= {sel_p[CALC_LAT-2:0], final_pass};
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        addr_p[0] <= atom_cnt;
        for (int i = 1; i < CALC_LAT; i++) begin
            addr_p[i] <= addr_p[i-1];
        end
    end

`ifdef NVDLA_CACC_SEQ_SAT_CNT_EN
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            sat_cnt <= '0;
        end else if (start) begin
            sat_cnt <= '0;
        end else if (calc_out_final_sat && (sat_cnt != 32'hFFFF_FFFF)) begin
            sat_cnt <= sat_cnt + 32'd1;
        end
    end
`else
    logic sat_unused;
    assign sat_unused = calc_out_final_sat;
    assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_calc_seq.sv
// Randomized bench for nv_nvdla_cacc_calc_seq against a transaction-level reference model.
module tb_nv_nvdla_cacc_calc_seq;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_en;
    logic [6:0]  cfg_stripe_len;
    logic [7:0]  cfg_chn_pass;
    logic [11:0] cfg_kernel_grp;
    logic        dat_pvld;
    logic        dat_prdy;
    logic [21:0] dat_pd;
    logic        abuf_rd_en;
    logic [6:0]  abuf_rd_addr;
    logic        abuf_wr_en;
    logic [6:0]  abuf_wr_addr;
    logic        calc_in_valid;
    logic        calc_in_sel;
    logic        calc_in_op_valid;
    logic [21:0] calc_in_data;
    logic        calc_out_final_sat;
    logic        dlv_credit_ret;
    logic        layer_done;
    logic [31:0] sat_cnt;

    always #5 clk = ~clk;

    nv_nvdla_cacc_calc_seq #(.DLV_DEPTH(DEPTH)) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rstn    (rst_n),
        .op_en              (op_en),
        .cfg_stripe_len     (cfg_stripe_len),
        .cfg_chn_pass       (cfg_chn_pass),
        .cfg_kernel_grp     (cfg_kernel_grp),
        .dat_pvld           (dat_pvld),
        .dat_prdy           (dat_prdy),
        .dat_pd             (dat_pd),
        .abuf_rd_en         (abuf_rd_en),
        .abuf_rd_addr       (abuf_rd_addr),
        .abuf_wr_en         (abuf_wr_en),
        .abuf_wr_addr       (abuf_wr_addr),
        .calc_in_valid      (calc_in_valid),
        .calc_in_sel        (calc_in_sel),
        .calc_in_op_valid   (calc_in_op_valid),
        .calc_in_data       (calc_in_data),
        .calc_out_final_sat (calc_out_final_sat),
        .dlv_credit_ret     (dlv_credit_ret),
        .layer_done         (layer_done),
        .sat_cnt            (sat_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a layer is a flat list of atoms; atom n sits at
    // (n mod stripe) within pass (n div stripe) mod passes.
    typedef struct { int due; int addr; } wb_t;
    wb_t         wq[$];
    int          cyc = 0;
    bit          m_run = 0;
    int          m_s = 0, m_c = 0, m_k = 0, m_total = 0, m_nacc = 0;
    int          m_credit = DEPTH;
    int          m_done_due = -1;
    int          m_zero_run = 0;
    longint      m_sat = 0;
    bit          ec_vld = 0, ec_op = 0, ec_sel = 0;
    logic [21:0] ec_data = '0;
    int          atom, pass;
    bit          fin, need, haz, exp_rdy, acc, op_acc, exp_wr;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_prdy", 64'(dat_prdy), 64'(0));
            check("rst_rd_en", 64'(abuf_rd_en), 64'(0));
            check("rst_wr_en", 64'(abuf_wr_en), 64'(0));
            check("rst_in_valid", 64'(calc_in_valid), 64'(0));
            check("rst_layer_done", 64'(layer_done), 64'(0));
            check("rst_sat_cnt", 64'(sat_cnt), 64'(0));
            m_run = 0; m_nacc = 0; m_done_due = -1; m_credit = DEPTH;
            m_sat = 0; ec_vld = 0; m_zero_run = 0;
            wq.delete();
        end else begin
            atom    = m_nacc % (m_s + 1);
            pass    = (m_nacc / (m_s + 1)) % (m_c + 1);
            fin     = (pass == m_c);
            need    = (pass != 0);
            haz     = 0;
            foreach (wq[i]) if (wq[i].addr == atom) haz = 1;
            exp_rdy = m_run && !(need && haz) && !(fin && m_credit == 0);
            acc     = dat_pvld && exp_rdy;
            op_acc  = op_en && !m_run && (cyc > m_done_due);

            check("dat_prdy", 64'(dat_prdy), 64'(exp_rdy));
            check("rd_en", 64'(abuf_rd_en), 64'(acc && need));
            if (acc && need) check("rd_addr", 64'(abuf_rd_addr), 64'(atom));
            check("in_valid", 64'(calc_in_valid), 64'(ec_vld));
            if (ec_vld) begin
                check("in_data", 64'(calc_in_data), 64'(ec_data));
                check("in_op_valid", 64'(calc_in_op_valid), 64'(ec_op));
                check("in_sel", 64'(calc_in_sel), 64'(ec_sel));
            end
            exp_wr = (wq.size() > 0) && (wq[0].due == cyc);
            check("wr_en", 64'(abuf_wr_en), 64'(exp_wr));
            if (exp_wr) begin
                check("wr_addr", 64'(abuf_wr_addr), 64'(wq[0].addr));
                void'(wq.pop_front());
            end
            check("layer_done", 64'(layer_done), 64'(cyc == m_done_due));
            check("sat_cnt", 64'(sat_cnt), 64'(m_sat));

            ec_vld = acc;
            if (acc) begin
                ec_data = dat_pd;
                ec_op   = need;
                ec_sel  = fin;
                if (!fin) wq.push_back('{cyc + LAT, atom});
                m_nacc++;
                if (m_nacc == m_total) begin
                    m_run = 0;
                    m_done_due = cyc + LAT + 1;
                end
            end
            m_credit = m_credit - ((acc && fin) ? 1 : 0) + (dlv_credit_ret ? 1 : 0);
            if (m_credit > DEPTH) m_credit = DEPTH;
`ifdef NVDLA_CACC_SEQ_SAT_CNT_EN
            if (op_acc) m_sat = 0;
            else if (calc_out_final_sat && m_sat != 64'hFFFF_FFFF) m_sat++;
`endif
            if (op_acc) begin
                m_run   = 1;
                m_s     = int'(cfg_stripe_len);
                m_c     = int'(cfg_chn_pass);
                m_k     = int'(cfg_kernel_grp);
                m_nacc  = 0;
                m_total = (m_s + 1) * (m_c + 1) * (m_k + 1);
            end
            m_zero_run = (m_credit == 0) ? m_zero_run + 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        op_en = 0; dat_pvld = 0; dlv_credit_ret = 0; calc_out_final_sat = 0;
    endtask

    task automatic refill();
        int guard = 0;
        while (m_credit < DEPTH && guard < 100) begin
            dlv_credit_ret = 1;
            tick();
            guard++;
        end
        dlv_credit_ret = 0;
    endtask

    task automatic run_layer(input int s, input int c, input int k, input int pv,
                             input int rp, input bit rst_mid);
        int budget;
        int rst_at;
        rst_at = (s + 1) + (s + 1) / 2 + 1;
        budget = 0;
        while ((m_run || cyc < m_done_due + 1) && budget < 50) begin
            tick();
            budget++;
        end
        cfg_stripe_len = 7'(s);
        cfg_chn_pass   = 8'(c);
        cfg_kernel_grp = 12'(k);
        op_en = 1;
        tick();
        op_en = 0;
        budget = 0;
        while (budget < 4000) begin
            if (!m_run && cyc >= m_done_due) break;
            cfg_stripe_len     = 7'($urandom);
            cfg_chn_pass       = 8'($urandom);
            cfg_kernel_grp     = 12'($urandom);
            dat_pvld           = ($urandom_range(99) < pv);
            dat_pd             = 22'($urandom);
            dlv_credit_ret     = ($urandom_range(99) < rp) || (m_zero_run >= 5);
            calc_out_final_sat = ($urandom_range(9) == 0);
            op_en              = m_run && ($urandom_range(19) == 0);
            if (rst_mid && m_nacc >= rst_at) begin
                #1 rst_n = 0;
                #1;
                check("async_prdy", 64'(dat_prdy), 64'(0));
                check("async_rd_en", 64'(abuf_rd_en), 64'(0));
                check("async_wr_en", 64'(abuf_wr_en), 64'(0));
                check("async_in_valid", 64'(calc_in_valid), 64'(0));
                check("async_in_sel", 64'(calc_in_sel), 64'(0));
                check("async_in_op", 64'(calc_in_op_valid), 64'(0));
                check("async_in_data", 64'(calc_in_data), 64'(0));
                check("async_sat_cnt", 64'(sat_cnt), 64'(0));
                drive_idle();
                tick();
                tick();
                rst_n = 1;
                tick();
                return;
            end
            tick();
            budget++;
        end
        if (budget >= 4000) check("layer_timeout", 64'(1), 64'(0));
        drive_idle();
    endtask

    initial begin
        drive_idle();
        cfg_stripe_len = '0;
        cfg_chn_pass   = '0;
        cfg_kernel_grp = '0;
        dat_pd         = '0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        run_layer(3, 0, 0, 100, 0, 0);
        refill();
        run_layer(7, 2, 0, 100, 20, 0);
        run_layer(0, 3, 0, 100, 20, 0);
        refill();
        run_layer(19, 0, 0, 100, 0, 0);
        run_layer(7, 3, 1, 100, 20, 1);
        run_layer(19, 0, 0, 100, 0, 0);
        for (int i = 0; i < 8; i++) begin
            run_layer($urandom_range(15), $urandom_range(3), $urandom_range(2),
                      $urandom_range(100, 40), $urandom_range(60, 10), 0);
        end
        repeat (10) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
